func_sweep_sequencer: RTL and testbench

FUNC_SWEEP_SEQUENCER -- requirements
Module: func_sweep_sequencer

---
 rtl/func_sweep_pkg.sv | 20 ++
 rtl/func_sweep_sequencer_if.sv | 30 +++
 rtl/func_sweep_sequencer_sweep_counter.sv | 63 ++++++
 rtl/func_sweep_sequencer.sv | 164 ++++++++++++++++
 tb/tb_func_sweep_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/func_sweep_pkg.sv
// Shared types and constants for the function sweep sequencer.
// Holds the FSM state encoding, the quiet-NaN result code and the parameter defaults.
package func_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int X_W_DEF     = 8;
  localparam int NUM_SEL_DEF = 9;
  localparam int SEL_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/func_sweep_sequencer_if.sv
// Evaluator request/ack channel and result record channel of the sweep sequencer.
// The master side is the sequencer; the slave side is the evaluator plus result consumer.
interface func_sweep_if #(
  parameter int X_W   = 8,
  parameter int SEL_W = 4
);

  logic [X_W-1:0]   dut_x;
  logic [SEL_W-1:0] dut_sel;
  logic             dut_req;
  logic             dut_ack;
  logic [31:0]      dut_out;
  logic             res_valid;
  logic             res_ready;
  logic [X_W-1:0]   res_x;
  logic [SEL_W-1:0] res_sel;
  logic [31:0]      res_data;
  logic             res_err;

  modport master (
    output dut_x, dut_sel, dut_req, res_valid, res_x, res_sel, res_data, res_err,
    input  dut_ack, dut_out, res_ready
  );

  modport slave (
    input  dut_x, dut_sel, dut_req, res_valid, res_x, res_sel, res_data, res_err,
    output dut_ack, dut_out, res_ready
  );

endinterface

// File: rtl/func_sweep_sequencer_sweep_counter.sv
// Nested (X outer, select inner) sweep position counter with modulo wrap of X.
// last is high while the current position is the final pair of the sweep.
module sweep_counter
  import func_sweep_pkg::*;
#(
  parameter int X_W     = X_W_DEF,
  parameter int NUM_SEL = NUM_SEL_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [X_W-1:0]   x_start,
  input  logic [X_W-1:0]   x_step,
  input  logic [7:0]       x_count,
  output logic [X_W-1:0]   x,
  output logic [SEL_W-1:0] sel,
  output logic             last
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SEL - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1'b1);

  logic [X_W-1:0]   x_r;
  logic [SEL_W-1:0] sel_r;
  logic [X_W-1:0]   step_r;
  logic [7:0]       cnt_r;
  logic [7:0]       idx_r;

  // Position registers: load on accepted start, step on each result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r    <= {X_W{1'b0}};
      sel_r  <= {SEL_W{1'b0}};
      step_r <= {X_W{1'b0}};
      cnt_r  <= 8'd0;
      idx_r  <= 8'd0;
    end else if (load) begin
      x_r    <= x_start;
      sel_r  <= {SEL_W{1'b0}};
      step_r <= x_step;
      cnt_r  <= x_count;
      idx_r  <= 8'd0;
    end else if (advance) begin
      if (sel_r == SEL_LAST) begin
        // X addition truncates to X_W, giving the permitted wrap-around
        sel_r <= {SEL_W{1'b0}};
        x_r   <= x_r + step_r;
        idx_r <= idx_r + 8'd1;
      end else begin
        sel_r <= sel_r + SEL_ONE;
      end
    end else begin
      x_r <= x_r;
    end
  end

  assign x    = x_r;
  assign sel  = sel_r;
  assign last = (sel_r == SEL_LAST) && (idx_r == (cnt_r - 8'd1));

endmodule

// File: rtl/func_sweep_sequencer.sv
// Sweeps an evaluator over x_count X values times NUM_SEL selects, one request at a time,
// and emits one result record per pair; unanswered requests time out into a quiet-NaN record.
module func_sweep_sequencer
  import func_sweep_pkg::*;
#(
  parameter int X_W     = X_W_DEF,
  parameter int NUM_SEL = NUM_SEL_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] x_start,
  input  logic [X_W-1:0] x_step,
  input  logic [7:0]     x_count,
  output logic           busy,
  output logic           done,
  output logic           err_sticky,
  func_sweep_if.master   bus
);

  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);

  state_t           state_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             dut_req_r;
  logic             res_valid_r;
  logic             res_err_r;
  logic [X_W-1:0]   res_x_r;
  logic [SEL_W-1:0] res_sel_r;
  logic [31:0]      res_data_r;
  logic             busy_r;
  logic             done_r;
  logic             err_sticky_r;

  logic             load_s;
  logic             advance_s;
  logic [X_W-1:0]   x_s;
  logic [SEL_W-1:0] sel_s;
  logic             last_s;

  assign load_s    = (state_r == ST_IDLE) && start && (x_count != 8'd0);
  assign advance_s = (state_r == ST_EMIT) && bus.res_ready;

  sweep_counter #(
    .X_W     (X_W),
    .NUM_SEL (NUM_SEL),
    .SEL_W   (SEL_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .advance (advance_s),
    .x_start (x_start),
    .x_step  (x_step),
    .x_count (x_count),
    .x       (x_s),
    .sel     (sel_s),
    .last    (last_s)
  );

  // Sequencer FSM with registered request, record and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      tmo_cnt_r    <= {TMO_W{1'b0}};
      dut_req_r    <= 1'b0;
      res_valid_r  <= 1'b0;
      res_err_r    <= 1'b0;
      res_x_r      <= {X_W{1'b0}};
      res_sel_r    <= {SEL_W{1'b0}};
      res_data_r   <= 32'h0000_0000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
            if (x_count != 8'd0) begin
              err_sticky_r <= 1'b0;
              dut_req_r    <= 1'b1;
              state_r      <= ST_ISSUE;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_FIN;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          tmo_cnt_r <= {TMO_W{1'b0}};
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          // ack is tested first so it wins over a timeout expiring in the same cycle
          if (bus.dut_ack) begin
            res_data_r  <= bus.dut_out;
            res_err_r   <= 1'b0;
            res_x_r     <= x_s;
            res_sel_r   <= sel_s;
            dut_req_r   <= 1'b0;
            res_valid_r <= 1'b1;
            state_r     <= ST_EMIT;
          end else if (tmo_cnt_r == TMO_LAST) begin
            res_data_r   <= QNAN;
            res_err_r    <= 1'b1;
            err_sticky_r <= 1'b1;
            res_x_r      <= x_s;
            res_sel_r    <= sel_s;
            dut_req_r    <= 1'b0;
            res_valid_r  <= 1'b1;
            state_r      <= ST_EMIT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_EMIT: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            if (last_s) begin
              done_r  <= 1'b1;
              state_r <= ST_FIN;
            end else begin
              dut_req_r <= 1'b1;
              state_r   <= ST_ISSUE;
            end
          end else begin
            res_valid_r <= 1'b1;
          end
        end
        ST_FIN: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          dut_req_r   <= 1'b0;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dut_x     = x_s;
  assign bus.dut_sel   = sel_s;
  assign bus.dut_req   = dut_req_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_x     = res_x_r;
  assign bus.res_sel   = res_sel_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_err   = res_err_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err_sticky    = err_sticky_r;

endmodule

// File: tb/tb_func_sweep_sequencer.sv
// Directed bench for func_sweep_sequencer: an evaluator responder, a record-list model of
// each sweep and a per-cycle compare process checking records, ordering and handshakes.
module tb_func_sweep_sequencer;

  typedef struct {
    logic [7:0]  x;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        err;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x_start, x_step, x_count;
  logic       busy, done, err_sticky;

  func_sweep_if #(.X_W(8), .SEL_W(4)) bus();

  func_sweep_sequencer #(.X_W(8), .NUM_SEL(9), .SEL_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .x_start(x_start), .x_step(x_step),
    .x_count(x_count), .busy(busy), .done(done), .err_sticky(err_sticky), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_rec = 0, stall_cycles = 0, req_rises = 0, done_cnt = 0;
  int ack_lat = 1;
  bit late_ack = 1'b0;
  rec_t exp_q[$];
  logic [7:0]  last_x;
  logic [3:0]  last_sel;
  logic [31:0] last_data;
  logic        last_err;

  function automatic logic [31:0] func_val(input logic [7:0] x, input logic [3:0] sel);
    return {12'h3F8, sel, 8'h00, x};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Evaluator: acks ack_lat cycles after it first sees a request (never when ack_lat < 0).
  initial begin
    int age;
    age = 0;
    bus.dut_ack = 1'b0;
    bus.dut_out = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      bus.dut_ack = 1'b0;
      bus.dut_out = 32'hDEAD_BEEF;
      if (late_ack) begin
        bus.dut_ack = 1'b1;
        bus.dut_out = 32'h1234_5678;
      end else if (bus.dut_req) begin
        age++;
        if (ack_lat >= 0 && age == ack_lat + 1) begin
          bus.dut_ack = 1'b1;
          bus.dut_out = func_val(bus.dut_x, bus.dut_sel);
        end
      end else begin
        age = 0;
      end
    end
  end

  // Per-cycle comparison against the expected record list and handshake rules.
  logic        hold_p = 1'b0, req_hold_p = 1'b0, ack_p = 1'b0, more_p = 1'b0, req_p = 1'b0;
  logic [7:0]  px, pdx;
  logic [3:0]  psel, pdsel;
  logic [31:0] pdata;
  logic        perr;
  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0; req_hold_p = 1'b0; ack_p = 1'b0; more_p = 1'b0; req_p = 1'b0;
    end else begin
      if (bus.res_valid) check("req_during_record", {31'd0, bus.dut_req}, 32'd0);
      if (ack_p) check("valid_after_ack", {31'd0, bus.res_valid}, 32'd1);
      if (more_p) check("req_after_handshake", {31'd0, bus.dut_req}, 32'd1);
      if (hold_p) begin
        check("hold_valid", {31'd0, bus.res_valid}, 32'd1);
        check("hold_x", {24'd0, bus.res_x}, {24'd0, px});
        check("hold_sel", {28'd0, bus.res_sel}, {28'd0, psel});
        check("hold_data", bus.res_data, pdata);
        check("hold_err", {31'd0, bus.res_err}, {31'd0, perr});
      end
      if (req_hold_p && bus.dut_req) begin
        check("req_x_stable", {24'd0, bus.dut_x}, {24'd0, pdx});
        check("req_sel_stable", {28'd0, bus.dut_sel}, {28'd0, pdsel});
      end
      more_p = 1'b0;
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 32'd1, 32'd0);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          check("rec_x", {24'd0, bus.res_x}, {24'd0, e.x});
          check("rec_sel", {28'd0, bus.res_sel}, {28'd0, e.sel});
          check("rec_data", bus.res_data, e.data);
          check("rec_err", {31'd0, bus.res_err}, {31'd0, e.err});
          more_p = (exp_q.size() != 0);
        end
        n_rec++;
        last_x = bus.res_x; last_sel = bus.res_sel; last_data = bus.res_data; last_err = bus.res_err;
      end
      if (bus.res_valid && !bus.res_ready) stall_cycles++;
      if (bus.dut_req && !req_p) req_rises++;
      if (done) done_cnt++;
      hold_p = bus.res_valid && !bus.res_ready;
      px = bus.res_x; psel = bus.res_sel; pdata = bus.res_data; perr = bus.res_err;
      req_hold_p = bus.dut_req && !bus.dut_ack;
      pdx = bus.dut_x; pdsel = bus.dut_sel;
      ack_p = bus.dut_req && bus.dut_ack;
      req_p = bus.dut_req;
    end
  end

  task automatic push_model(input logic [7:0] xs, input logic [7:0] st, input int cn, input bit tmo);
    for (int i = 0; i < cn; i++) begin
      for (int s = 0; s < 9; s++) begin
        rec_t r;
        r.x    = 8'((int'(xs) + i * int'(st)) % 256);
        r.sel  = 4'(s);
        r.data = tmo ? 32'h7FC0_0000 : func_val(r.x, r.sel);
        r.err  = tmo;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic do_start(input logic [7:0] xs, input logic [7:0] st, input logic [7:0] cn);
    x_start = xs; x_step = st; x_count = cn; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
    tick();
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_all_records"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, {31'd0, bus.dut_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.res_valid}, 32'd0);
    check({tag, "_err"}, {31'd0, bus.res_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_sticky"}, {31'd0, err_sticky}, 32'd0);
    check({tag, "_dut_x_sel"}, {20'd0, bus.dut_x, bus.dut_sel}, 32'd0);
    check({tag, "_res_x_sel"}, {20'd0, bus.res_x, bus.res_sel}, 32'd0);
    check({tag, "_res_data"}, bus.res_data, 32'd0);
  endtask

  initial begin
    int r0, d0, q0, s0, n;
    rst = 1'b1; start = 1'b0; x_start = 8'd0; x_step = 8'd0; x_count = 8'd0;
    bus.res_ready = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // 9 records at X=2, sel 0..8
    r0 = n_rec; d0 = done_cnt;
    push_model(8'd2, 8'd1, 1, 1'b0);
    do_start(8'd2, 8'd1, 8'd1);
    check("a_req_after_start", {31'd0, bus.dut_req}, 32'd1);
    wait_done("a_done");
    check("a_count", n_rec - r0, 32'd9);
    check("a_done_pulses", done_cnt - d0, 32'd1);
    check("a_last_sel", {28'd0, last_sel}, 32'd8);
    check("a_last_data", last_data, 32'h3F88_0002);

    // X wraps FE, FF, 00
    r0 = n_rec;
    push_model(8'hFE, 8'd1, 3, 1'b0);
    do_start(8'hFE, 8'd1, 8'd3);
    wait_done("b_done");
    check("b_count", n_rec - r0, 32'd27);
    check("b_last_x", {24'd0, last_x}, 32'd0);

    // 10-cycle backpressure on record 3
    r0 = n_rec; s0 = stall_cycles;
    push_model(8'h40, 8'd3, 1, 1'b0);
    do_start(8'h40, 8'd3, 8'd1);
    n = 0;
    while (!((n_rec - r0) == 3 && bus.res_valid) && n < 200) begin
      tick();
      n++;
    end
    check("c_reach_rec3", {31'd0, bus.res_valid}, 32'd1);
    bus.res_ready = 1'b0;
    repeat (10) tick();
    bus.res_ready = 1'b1;
    wait_done("c_done");
    check("c_stall_cycles", stall_cycles - s0, 32'd10);
    check("c_count", n_rec - r0, 32'd9);

    // evaluator never answers: every record times out
    ack_lat = -1;
    push_model(8'h11, 8'd1, 1, 1'b1);
    do_start(8'h11, 8'd1, 8'd1);
    wait_done("d_done");
    check("d_last_data", last_data, 32'h7FC0_0000);
    check("d_last_err", {31'd0, last_err}, 32'd1);
    check("d_sticky", {31'd0, err_sticky}, 32'd1);
    ack_lat = 1;
    push_model(8'd5, 8'd1, 1, 1'b0);
    do_start(8'd5, 8'd1, 8'd1);
    check("e_sticky_cleared", {31'd0, err_sticky}, 32'd0);
    wait_done("e_done");

    // empty sweep
    q0 = req_rises; d0 = done_cnt;
    do_start(8'd7, 8'd1, 8'd0);
    check("f_done_next_cycle", {31'd0, done}, 32'd1);
    check("f_busy", {31'd0, busy}, 32'd1);
    tick();
    check("f_done_one_cycle", {31'd0, done}, 32'd0);
    tick();
    check("f_no_req", req_rises - q0, 32'd0);
    check("f_done_pulses", done_cnt - d0, 32'd1);

    // reset while waiting on record 5
    ack_lat = 3;
    r0 = n_rec;
    push_model(8'h20, 8'd1, 1, 1'b0);
    do_start(8'h20, 8'd1, 8'd1);
    n = 0;
    while (!((n_rec - r0) == 5 && bus.dut_req) && n < 200) begin
      tick();
      n++;
    end
    check("g_reach_rec5", {31'd0, bus.dut_req}, 32'd1);
    tick();
    tick();
    ack_lat = -1;
    rst = 1'b1;
    tick();
    check_zero("g_rst");
    rst = 1'b0;
    exp_q.delete();
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    repeat (3) tick();
    check("g_late_ack_busy", {31'd0, busy}, 32'd0);
    check("g_late_ack_valid", {31'd0, bus.res_valid}, 32'd0);
    check("g_late_ack_req", {31'd0, bus.dut_req}, 32'd0);
    check("g_records", n_rec - r0, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
